// File: rtl/psum_reduce_accumulator.sv
// Reduces PE-array partial sums per column (or per half-array), accumulates them
// into a saturating multi-lane buffer, and drains the buffer to BRAM on request.
module psum_reduce_accumulator #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int DEPTH                 = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_out,
    input  logic                                  pe_psum_finish,
    input  logic                                  conv_finish,
    input  logic                                  cfg_mode,
    input  logic                                  cfg_relu,
    input  logic [PSUM_RF_ADDR_BITWIDTH:0]        cfg_rf_cnt,
    input  logic [$clog2(DEPTH)-1:0]              cfg_acc_base,
    input  logic [$clog2(DEPTH):0]                cfg_drain_cnt,
    input  logic [9:0]                            cfg_out_base,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr,
    output logic                                  su_add_finish,
    output logic [GBF_DATA_BITWIDTH-1:0]          out_data,
    output logic                                  psum_write_en,
    output logic [9:0]                            psum_BRAM_addr,
    output logic                                  busy,
    output logic                                  drain_done
);

    localparam int DW  = DATA_BITWIDTH;
    localparam int AW  = PSUM_RF_ADDR_BITWIDTH;
    localparam int AB  = $clog2(DEPTH);
    localparam int L   = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int SW  = DATA_BITWIDTH + $clog2(ROW) + 1;
    localparam int RCW = PSUM_RF_ADDR_BITWIDTH + 2;
    localparam int unsigned HALF_ROW = ROW / 2;
    localparam logic signed [SW:0] SAT_MAX = (SW+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [SW:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t                       state_q, state_d;

    logic [RCW-1:0]               acc_cyc_q;
    logic [AB:0]                  dr_cyc_q;
    logic [AW:0]                  rf_cnt_q;
    logic [AB-1:0]                acc_base_q;
    logic                         acc_mode_q;
    logic                         drain_pending_q;
    logic                         relu_q;
    logic [AB:0]                  drain_cnt_q;
    logic [9:0]                   out_base_q;
    logic [DEPTH-1:0]             valid_q;
    logic [GBF_DATA_BITWIDTH-1:0] acc_mem [DEPTH];

    logic                         acc_issue, acc_sample, acc_last, drain_last;
    logic                         cap_drain, rd_go;
    logic                         eff_relu;
    logic [AB:0]                  eff_cnt;
    logic [9:0]                   eff_base;
    logic [AB:0]                  rd_pos;
    logic [AB-1:0]                rd_idx;
    logic [AB-1:0]                sample_idx;
    logic signed [SW-1:0]         red [L];
    logic [GBF_DATA_BITWIDTH-1:0] acc_word;
    logic [GBF_DATA_BITWIDTH-1:0] rd_word;

    function automatic logic [DW-1:0] saturate(input logic signed [SW:0] v);
        if (v > SAT_MAX) return SAT_MAX[DW-1:0];
        if (v < SAT_MIN) return SAT_MIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Drain config is effective from the edge that accepts conv_finish, so the
    // first entry read can be issued on that same edge.
    always_comb begin
        state_d    = state_q;
        rd_go      = 1'b0;
        rd_pos     = '0;
        acc_issue  = (state_q == ACC) && (acc_cyc_q < RCW'(rf_cnt_q));
        acc_sample = (state_q == ACC) && (acc_cyc_q != '0) && (acc_cyc_q <= RCW'(rf_cnt_q));
        acc_last   = (state_q == ACC) && (acc_cyc_q == RCW'(rf_cnt_q) + RCW'(1));
        drain_last = (state_q == DRAIN) && (dr_cyc_q == drain_cnt_q);
        cap_drain  = conv_finish && ((state_q == IDLE) || ((state_q == ACC) && !drain_pending_q));
        eff_relu   = cap_drain ? cfg_relu      : relu_q;
        eff_cnt    = cap_drain ? cfg_drain_cnt : drain_cnt_q;
        eff_base   = cap_drain ? cfg_out_base  : out_base_q;
        case (state_q)
            IDLE: begin
                if (pe_psum_finish) begin
                    state_d = ACC;
                end else if (conv_finish) begin
                    state_d = DRAIN;
                    rd_go   = (eff_cnt != '0);
                end
            end
            ACC: begin
                if (acc_last) begin
                    if (drain_pending_q || conv_finish) begin
                        state_d = DRAIN;
                        rd_go   = (eff_cnt != '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = IDLE;
                end else begin
                    rd_pos = dr_cyc_q + (AB+1)'(1);
                    rd_go  = (rd_pos < drain_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sample_idx = acc_base_q + AB'(acc_cyc_q - RCW'(1));
    assign rd_idx     = rd_pos[AB-1:0];

    always_comb begin
        logic signed [DW-1:0] pe_val;
        logic signed [SW-1:0] pe_ext;
        pe_val = '0;
        pe_ext = '0;
        for (int unsigned l = 0; l < L; l++) red[l] = '0;
        for (int unsigned r = 0; r < ROW; r++) begin
            for (int unsigned c = 0; c < COL; c++) begin
                pe_val = psum_out[(r*COL + c)*DW +: DW];
                pe_ext = SW'(pe_val);
                if (!acc_mode_q || r < HALF_ROW) red[c] = red[c] + pe_ext;
                else                              red[COL + c] = red[COL + c] + pe_ext;
            end
        end
    end

    always_comb begin
        logic signed [DW-1:0] old_lane;
        logic signed [SW:0]   old_ext;
        acc_word = '0;
        old_lane = '0;
        old_ext  = '0;
        for (int unsigned l = 0; l < L; l++) begin
            old_lane = acc_mem[sample_idx][l*DW +: DW];
            old_ext  = valid_q[sample_idx] ? (SW+1)'(old_lane) : '0;
            acc_word[l*DW +: DW] = saturate(old_ext + (SW+1)'(red[l]));
        end
    end

    always_comb begin
        logic [DW-1:0] lane;
        rd_word = '0;
        lane    = '0;
        if (valid_q[rd_idx]) begin
            for (int unsigned l = 0; l < L; l++) begin
                lane = acc_mem[rd_idx][l*DW +: DW];
                rd_word[l*DW +: DW] = (eff_relu && lane[DW-1]) ? '0 : lane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && acc_sample) acc_mem[sample_idx] <= acc_word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_cyc_q       <= '0;
            dr_cyc_q        <= '0;
            rf_cnt_q        <= '0;
            acc_base_q      <= '0;
            acc_mode_q      <= 1'b0;
            drain_pending_q <= 1'b0;
            relu_q          <= 1'b0;
            drain_cnt_q     <= '0;
            out_base_q      <= '0;
            valid_q         <= '0;
            psum_write_en   <= 1'b0;
            psum_BRAM_addr  <= '0;
            out_data        <= '0;
        end else begin
            acc_cyc_q <= (state_q == ACC)   ? acc_cyc_q + RCW'(1)  : '0;
            dr_cyc_q  <= (state_q == DRAIN) ? dr_cyc_q + (AB+1)'(1) : '0;
            if (state_q == IDLE && pe_psum_finish) begin
                rf_cnt_q   <= cfg_rf_cnt;
                acc_base_q <= cfg_acc_base;
                acc_mode_q <= cfg_mode;
            end
            if (cap_drain) begin
                relu_q      <= cfg_relu;
                drain_cnt_q <= cfg_drain_cnt;
                out_base_q  <= cfg_out_base;
            end
            if (drain_last)
                drain_pending_q <= 1'b0;
            else if ((state_q == IDLE && pe_psum_finish && conv_finish) ||
                     (state_q == ACC && conv_finish))
                drain_pending_q <= 1'b1;
            if (acc_sample) valid_q[sample_idx] <= 1'b1;
            if (rd_go)      valid_q[rd_idx]     <= 1'b0;
            psum_write_en  <= rd_go;
            psum_BRAM_addr <= rd_go ? eff_base + 10'(rd_pos) : '0;
            out_data       <= rd_go ? rd_word : '0;
        end
    end

    assign psum_rf_addr  = acc_issue ? acc_cyc_q[AW-1:0] : '0;
    assign su_add_finish = acc_last;
    assign drain_done    = drain_last;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_psum_reduce_accumulator.sv
// Directed bench: expected BRAM writes are queued by the stimulus and popped by
// an independent write monitor; pulse/address timing is checked inline.
module tb_psum_reduce_accumulator;

    logic           clk;
    logic           reset;
    logic [4095:0]  psum_out;
    logic           pe_psum_finish, conv_finish, cfg_mode, cfg_relu;
    logic [2:0]     cfg_rf_cnt;
    logic [4:0]     cfg_acc_base;
    logic [5:0]     cfg_drain_cnt;
    logic [9:0]     cfg_out_base;
    logic [1:0]     psum_rf_addr;
    logic           su_add_finish, psum_write_en, busy, drain_done;
    logic [511:0]   out_data;
    logic [9:0]     psum_BRAM_addr;

    typedef struct {
        logic [9:0]   addr;
        logic [511:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    psum_reduce_accumulator #(
        .ROW(16), .COL(16), .DATA_BITWIDTH(16), .GBF_DATA_BITWIDTH(512),
        .PSUM_RF_ADDR_BITWIDTH(2), .DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset), .psum_out(psum_out),
        .pe_psum_finish(pe_psum_finish), .conv_finish(conv_finish),
        .cfg_mode(cfg_mode), .cfg_relu(cfg_relu), .cfg_rf_cnt(cfg_rf_cnt),
        .cfg_acc_base(cfg_acc_base), .cfg_drain_cnt(cfg_drain_cnt),
        .cfg_out_base(cfg_out_base), .psum_rf_addr(psum_rf_addr),
        .su_add_finish(su_add_finish), .out_data(out_data),
        .psum_write_en(psum_write_en), .psum_BRAM_addr(psum_BRAM_addr),
        .busy(busy), .drain_done(drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endfunction

    function automatic logic [511:0] lanes2(input logic [15:0] lo, input logic [15:0] hi);
        logic [511:0] w;
        for (int l = 0; l < 32; l++) w[l*16 +: 16] = (l < 16) ? lo : hi;
        return w;
    endfunction

    // PE(r,c) = c-8: mode 0 gives 16*(c-8) per column, mode 1 gives 8*(c-8) per half.
    function automatic logic [511:0] col_word(input logic mode1, input logic relu);
        logic [511:0] w;
        int v;
        w = '0;
        for (int c = 0; c < 16; c++) begin
            v = (mode1 ? 8 : 16) * (c - 8);
            if (relu && v < 0) v = 0;
            w[c*16 +: 16] = 16'(v);
            if (mode1) w[(c+16)*16 +: 16] = 16'(v);
        end
        return w;
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (psum_write_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {502'd0, psum_BRAM_addr}, 512'h3ff_dead);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {502'd0, psum_BRAM_addr}, {502'd0, e.addr});
                check("wr_data", out_data, e.data);
            end
        end
    end

    task automatic push_wr(input logic [9:0] addr, input logic [511:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_pe_all(input logic [15:0] v);
        for (int i = 0; i < 256; i++) psum_out[i*16 +: 16] = v;
    endtask

    task automatic set_pe_col();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                psum_out[(r*16 + c)*16 +: 16] = 16'(c) - 16'd8;
    endtask

    task automatic scramble_cfg();
        cfg_mode      = ~cfg_mode;
        cfg_rf_cnt    = 3'd7;
        cfg_acc_base  = cfg_acc_base + 5'd7;
        cfg_relu      = ~cfg_relu;
        cfg_drain_cnt = 6'd63;
        cfg_out_base  = 10'h2aa;
    endtask

    // Called at a negedge; returns at the negedge after the su_add_finish cycle.
    task automatic run_pass(input logic mode, input logic [2:0] rf, input logic [4:0] base, input logic conv);
        pe_psum_finish = 1'b1;
        conv_finish    = conv;
        cfg_mode       = mode;
        cfg_rf_cnt     = rf;
        cfg_acc_base   = base;
        @(negedge clk);
        pe_psum_finish = 1'b0;
        conv_finish    = 1'b0;
        scramble_cfg();
        for (int k = 0; k <= int'(rf) + 1; k++) begin
            check("busy_acc", busy, 1'b1);
            check("rf_addr", psum_rf_addr, (k < int'(rf)) ? k : 0);
            check("su_add_finish", su_add_finish, k == int'(rf) + 1);
            @(negedge clk);
        end
        if (!conv) check("busy_after_pass", busy, 1'b0);
    endtask

    task automatic run_drain(input logic [5:0] cnt, input logic [9:0] base, input logic relu);
        conv_finish   = 1'b1;
        cfg_drain_cnt = cnt;
        cfg_out_base  = base;
        cfg_relu      = relu;
        @(negedge clk);
        conv_finish = 1'b0;
        scramble_cfg();
        for (int j = 0; j <= int'(cnt); j++) begin
            check("busy_drain", busy, 1'b1);
            check("wr_en", psum_write_en, j < int'(cnt));
            check("drain_done", drain_done, j == int'(cnt));
            @(negedge clk);
        end
        check("busy_after_drain", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; pe_psum_finish = 1'b0; conv_finish = 1'b0;
        cfg_mode = 1'b0; cfg_relu = 1'b0; cfg_rf_cnt = '0; cfg_acc_base = '0;
        cfg_drain_cnt = '0; cfg_out_base = '0; psum_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", psum_write_en, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_bram_addr", psum_BRAM_addr, '0);
        check("rst_rf_addr", psum_rf_addr, '0);
        check("rst_su", su_add_finish, 1'b0);
        check("rst_drain_done", drain_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;

        push_wr(10'd0, '0);
        run_drain(6'd1, 10'd0, 1'b0);

        set_pe_all(16'd1);
        run_pass(1'b0, 3'd1, 5'd0, 1'b0);
        push_wr(10'd5, lanes2(16'd16, 16'd0));
        run_drain(6'd1, 10'd5, 1'b0);

        run_pass(1'b1, 3'd1, 5'd0, 1'b0);
        set_pe_all(16'd2);
        run_pass(1'b1, 3'd1, 5'd0, 1'b0);
        push_wr(10'd0, lanes2(16'd24, 16'd24));
        push_wr(10'd1, '0);
        run_drain(6'd2, 10'd0, 1'b0);
        set_pe_all(16'd1);
        run_pass(1'b1, 3'd1, 5'd0, 1'b0);
        push_wr(10'd0, lanes2(16'd8, 16'd8));
        run_drain(6'd1, 10'd0, 1'b0);

        set_pe_all(16'h7fff);
        run_pass(1'b0, 3'd1, 5'd0, 1'b0);
        run_pass(1'b0, 3'd1, 5'd0, 1'b0);
        push_wr(10'd0, lanes2(16'h7fff, 16'd0));
        run_drain(6'd1, 10'd0, 1'b0);
        set_pe_all(16'h8000);
        run_pass(1'b0, 3'd1, 5'd0, 1'b0);
        push_wr(10'd0, lanes2(16'h8000, 16'd0));
        run_drain(6'd1, 10'd0, 1'b0);
        run_pass(1'b0, 3'd1, 5'd0, 1'b0);
        push_wr(10'd0, '0);
        run_drain(6'd1, 10'd0, 1'b1);

        set_pe_col();
        run_pass(1'b1, 3'd1, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) push_wr(10'(20 + i), '0);
        push_wr(10'd23, col_word(1'b1, 1'b0));
        run_drain(6'd4, 10'd20, 1'b0);
        run_pass(1'b0, 3'd1, 5'd3, 1'b0);
        push_wr(10'd1022, '0);
        push_wr(10'd1023, '0);
        push_wr(10'd0, '0);
        push_wr(10'd1, col_word(1'b0, 1'b1));
        run_drain(6'd4, 10'd1022, 1'b1);

        set_pe_all(16'd3);
        run_pass(1'b0, 3'd2, 5'd31, 1'b0);
        for (int i = 0; i < 32; i++)
            push_wr(10'(100 + i), (i == 0 || i == 31) ? lanes2(16'd48, 16'd0) : '0);
        run_drain(6'd32, 10'd100, 1'b0);

        run_pass(1'b0, 3'd0, 5'd0, 1'b0);
        push_wr(10'd0, '0);
        run_drain(6'd1, 10'd0, 1'b0);
        run_drain(6'd0, 10'd0, 1'b0);

        set_pe_all(16'd1);
        run_pass(1'b0, 3'd1, 5'd2, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) push_wr(10'(i), '0);
        run_drain(6'd3, 10'd0, 1'b0);

        cfg_drain_cnt = 6'd4;
        cfg_out_base  = 10'd10;
        cfg_relu      = 1'b0;
        push_wr(10'd10, lanes2(16'd16, 16'd0));
        push_wr(10'd11, '0);
        run_pass(1'b0, 3'd1, 5'd0, 1'b1);
        check("no_idle_gap", busy, 1'b1);
        check("chain_wr_en", psum_write_en, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_wr_en", psum_write_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_drain_done", drain_done, 1'b0);
        @(negedge clk);
        check("abort_wr_en2", psum_write_en, 1'b0);
        reset = 1'b1;

        repeat (3) @(negedge clk);
        check("queue_empty", 512'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_reduce_accumulator.md
PSUM_REDUCE_ACCUMULATOR -- requirements
Module: psum_reduce_accumulator

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ROW, 16, PE array rows.
- COL, 16, PE array columns.
- DATA_BITWIDTH, 16, signed psum width (DW).
- GBF_DATA_BITWIDTH, 512, output word width; SHALL be >= 2*COL*DW.
- PSUM_RF_ADDR_BITWIDTH, 2, PE psum RF address width.
- DEPTH, 32, accumulation buffer entries; SHALL be a power of two.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-low.
- psum_out, in, DW*ROW*COL, PE(r,c) psum at bits [(r*COL+c)*DW +: DW].
- pe_psum_finish, in, 1, start accumulation pass.
- conv_finish, in, 1, start drain.
- cfg_mode, in, 1, 0 = full column reduce; 1 = half-array reduce.
- cfg_relu, in, 1, clamp negatives to 0 on drain.
- cfg_rf_cnt, in, PSUM_RF_ADDR_BITWIDTH+1, RF entries per pass.
- cfg_acc_base, in, log2(DEPTH), buffer start address for the pass.
- cfg_drain_cnt, in, log2(DEPTH)+1, entries to drain.
- cfg_out_base, in, 10, first BRAM address for the drain.
- psum_rf_addr, out, PSUM_RF_ADDR_BITWIDTH, PE RF read address.
- su_add_finish, out, 1, one-cycle pulse at pass end.
- out_data, out, GBF_DATA_BITWIDTH, drain write data.
- psum_write_en, out, 1, BRAM write strobe.
- psum_BRAM_addr, out, 10, BRAM write address.
- busy, out, 1, high whenever state != IDLE.
- drain_done, out, 1, one-cycle pulse at drain end.

Function
REQ-003 States SHALL be IDLE, ACC and DRAIN.
REQ-004 Configuration inputs SHALL be sampled when the command is accepted and ignored thereafter.
REQ-005 In IDLE, pe_psum_finish=1 SHALL move the block to ACC.
- If conv_finish is also 1 in that cycle, it SHALL be latched as drain_pending.
- pe_psum_finish SHALL be ignored outside IDLE.
REQ-006 ACC address issue: psum_rf_addr SHALL be 0 in the first ACC cycle and increment by 1 per cycle for cfg_rf_cnt cycles.
REQ-007 ACC sampling: psum_out SHALL be sampled one cycle after the corresponding psum_rf_addr value (RF read latency 1).
REQ-008 Reduction, in full precision (DW+log2(ROW)+1 bits), with L = GBF_DATA_BITWIDTH/DW lanes:
- mode 0: lane c = sum over all r of PE(r,c); lanes COL..L-1 = 0.
- mode 1: lane c = sum over r<ROW/2; lane COL+c = sum over r>=ROW/2; lanes >= 2*COL = 0.
REQ-009 Sample k SHALL update buffer entry (cfg_acc_base+k) mod DEPTH on the same edge it is sampled.
- Entry valid bit clear: store the reduced value and set valid.
- Entry valid bit set: store the old value plus the reduced value, per lane.
- Each stored lane SHALL be saturated to signed DW.
REQ-010 One cycle after the last update, su_add_finish SHALL pulse for one cycle. The next state SHALL be DRAIN if drain_pending, else IDLE.
REQ-011 conv_finish asserted during ACC SHALL set drain_pending. conv_finish in IDLE with pe_psum_finish=0 SHALL enter DRAIN directly.
REQ-012 cfg_rf_cnt=0 SHALL perform no buffer update; su_add_finish SHALL pulse in the second cycle after acceptance.
REQ-013 DRAIN read: entries 0..cfg_drain_cnt-1 SHALL be read in order, one per cycle, with 1-cycle registered read latency.
REQ-014 DRAIN write: for each entry, psum_write_en=1 with psum_BRAM_addr = cfg_out_base+i (mod 1024) and out_data = entry. With cfg_relu=1, negative lanes SHALL be output as 0.
REQ-015 Each drained entry's valid bit SHALL be cleared. Invalid entries SHALL drain as all zeros.
REQ-016 drain_done SHALL pulse in the cycle after the last write; the state SHALL then return to IDLE and drain_pending SHALL clear.
- cfg_drain_cnt=0: no writes; drain_done SHALL pulse the cycle after acceptance.
REQ-017 psum_write_en SHALL be 0 in all cycles other than drain writes.
REQ-018 Entry address SHALL wrap from DEPTH-1 to 0 without any error indication.

Reset
REQ-019 While reset=0 at a clock edge:
- State SHALL go to IDLE.
- All outputs SHALL be 0 (out_data included), with busy=0.
- All valid bits and drain_pending SHALL clear.
REQ-020 Reset asserted mid-ACC or mid-DRAIN SHALL abort the operation. No write or pulse SHALL occur from the following edge onward.

Verification
REQ-021 Hold reset=0 for 2 cycles -> all outputs 0, busy=0; a subsequent drain with cfg_drain_cnt=1 outputs all-zero data.
REQ-022 All PEs=1, mode 0, rf_cnt=1, acc_base=0; then drain with cnt=1, out_base=5 -> one write at addr 5, lanes 0-15=16, lanes 16-31=0; drain_done one cycle later.
REQ-023 Two passes (all PEs=1, then all PEs=2), mode 1 -> all 32 lanes = 24; drain clears valid; a third pass of 1 plus drain gives 8.
REQ-024 All PEs=16'h7FFF -> lanes 16'h7FFF; all PEs=16'h8000 with cfg_relu=1 -> lanes 0.
REQ-025 acc_base=31, rf_cnt=2 -> entries 31 and 0 written, psum_rf_addr sequence 0,1, then su_add_finish pulse.
REQ-026 pe_psum_finish and conv_finish asserted together in IDLE -> ACC completes, su_add_finish pulses, DRAIN begins with no IDLE cycle in between; reset=0 mid-DRAIN -> psum_write_en=0 from the next edge.
